// File: rtl/fpu_csr_pkg.sv
// fpu_csr_pkg: CSR addresses, CSR instruction ops and sequencer states shared by the CSR access path
package fpu_csr_pkg;
   localparam logic [11:0] MSTATUS = 12'h300;
   localparam logic [11:0] MTVEC   = 12'h305;
   localparam logic [11:0] MEPC    = 12'h341;
   localparam logic [11:0] MCAUSE  = 12'h342;
   localparam logic [11:0] MTVAL   = 12'h343;
   localparam logic [11:0] FFLAGS  = 12'h001;
   localparam logic [11:0] FRM     = 12'h002;
   localparam logic [11:0] FCSR    = 12'h003;
   typedef enum logic [1:0] {RO = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11} csr_op_e;
   typedef enum logic [3:0] {
      IDLE, RMW_RD, RMW_WR, FLG_RD, FLG_WR, TRP_EPC, TRP_CAUSE, TRP_TVAL, TRP_VEC
   } csr_ctrl_state_e;
endpackage

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: new value and write enable for CSRRW/CSRRS/CSRRC; set/clear with zero operand does not write
module csr_rmw_alu
   import fpu_csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  csr_op_e           op,
   input  logic [XLEN-1:0]   old,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   nval,
   output logic              we
);
   assign nval = op == RW ? wdata : op == RS ? (old | wdata) : op == RC ? (old & ~wdata) : old;
   assign we   = op == RW || (op != RO && wdata != '0);
endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: arbitrates trap entry, core CSR instructions and sticky FPU flags onto one CSR write port
module csr_access_ctrl
   import fpu_csr_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12,
   parameter int FLAG_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trap_req,
   input  logic [XLEN-1:0]   trap_epc,
   input  logic [XLEN-1:0]   trap_cause,
   input  logic [XLEN-1:0]   trap_tval,
   output logic              trap_done,
   output logic [XLEN-1:0]   trap_vec,
   input  logic              csr_req_valid,
   output logic              csr_req_ready,
   input  logic [1:0]        csr_req_op,
   input  logic [ADDR_W-1:0] csr_req_addr,
   input  logic [XLEN-1:0]   csr_req_wdata,
   output logic              csr_rsp_valid,
   output logic [XLEN-1:0]   csr_rsp_rdata,
   input  logic              fpu_flag_valid,
   input  logic [FLAG_W-1:0] fpu_flags,
   output logic              csrW_en,
   output logic [ADDR_W-1:0] csr_address_w,
   output logic [XLEN-1:0]   csr_data_w,
   output logic [ADDR_W-1:0] csr_address_r,
   input  logic [XLEN-1:0]   csr_data_r
);
   csr_ctrl_state_e   state;
   csr_op_e           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q, old_q, epc_q, cause_q, tval_q, vec_q, rmw_val;
   logic [FLAG_W-1:0] pend_flags, snap, flags_in;
   logic              rmw_we;
   csr_rmw_alu #(.XLEN(XLEN)) u_alu (
      .op(op_q), .old(old_q), .wdata(wdata_q), .nval(rmw_val), .we(rmw_we)
   );
   assign flags_in      = fpu_flag_valid ? fpu_flags : '0;
   assign csr_req_ready = rst && state == IDLE && !trap_req && csr_req_valid;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= IDLE;
         op_q       <= RO;
         addr_q     <= '0;
         wdata_q    <= '0;
         old_q      <= '0;
         epc_q      <= '0;
         cause_q    <= '0;
         tval_q     <= '0;
         vec_q      <= '0;
         pend_flags <= '0;
         snap       <= '0;
      end else begin
         // only the snapshot being committed is retired; newer arrivals stay pending
         pend_flags <= state == FLG_WR ? (pend_flags & ~snap) | flags_in : pend_flags | flags_in;
         case (state)
            IDLE:
               if (trap_req) begin
                  epc_q   <= trap_epc;
                  cause_q <= trap_cause;
                  tval_q  <= trap_tval;
                  state   <= TRP_EPC;
               end else if (csr_req_valid) begin
                  op_q    <= csr_op_e'(csr_req_op);
                  addr_q  <= csr_req_addr;
                  wdata_q <= csr_req_wdata;
                  state   <= RMW_RD;
               end else if (pend_flags != '0) state <= FLG_RD;
            RMW_RD: begin
               old_q <= csr_data_r;
               state <= RMW_WR;
            end
            FLG_RD: begin
               old_q <= csr_data_r;
               snap  <= pend_flags;
               state <= FLG_WR;
            end
            TRP_EPC:   state <= TRP_CAUSE;
            TRP_CAUSE: state <= TRP_TVAL;
            TRP_TVAL:  state <= TRP_VEC;
            TRP_VEC: begin
               vec_q <= csr_data_r;
               state <= IDLE;
            end
            default:   state <= IDLE;
         endcase
      end
   always_comb begin
      csrW_en       = 1'b0;
      csr_address_w = '0;
      csr_data_w    = '0;
      csr_address_r = '0;
      csr_rsp_valid = state == RMW_WR;
      csr_rsp_rdata = state == RMW_WR ? old_q : '0;
      trap_done     = state == TRP_VEC;
      trap_vec      = state == TRP_VEC ? csr_data_r : vec_q;
      case (state)
         RMW_RD: csr_address_r = addr_q;
         RMW_WR: begin
            csrW_en       = rmw_we;
            csr_address_w = addr_q;
            csr_data_w    = rmw_val;
         end
         FLG_RD: csr_address_r = ADDR_W'(FFLAGS);
         FLG_WR: begin
            csrW_en       = 1'b1;
            csr_address_w = ADDR_W'(FFLAGS);
            csr_data_w    = XLEN'(old_q[FLAG_W-1:0] | snap);
         end
         TRP_EPC: begin
            csrW_en       = 1'b1;
            csr_address_w = ADDR_W'(MEPC);
            csr_data_w    = epc_q;
         end
         TRP_CAUSE: begin
            csrW_en       = 1'b1;
            csr_address_w = ADDR_W'(MCAUSE);
            csr_data_w    = cause_q;
         end
         TRP_TVAL: begin
            csrW_en       = 1'b1;
            csr_address_w = ADDR_W'(MTVAL);
            csr_data_w    = tval_q;
         end
         TRP_VEC: csr_address_r = ADDR_W'(MTVEC);
         default: ;
      endcase
   end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed checks of csr_access_ctrl against a negedge-written CSR file model
module tb_csr_access_ctrl;
   logic        clk = 1'b0, rst = 1'b0;
   logic        trap_req = 1'b0, trap_done;
   logic [31:0] trap_epc = '0, trap_cause = '0, trap_tval = '0, trap_vec;
   logic        csr_req_valid = 1'b0, csr_req_ready;
   logic [1:0]  csr_req_op = '0;
   logic [11:0] csr_req_addr = '0;
   logic [31:0] csr_req_wdata = '0;
   logic        csr_rsp_valid;
   logic [31:0] csr_rsp_rdata;
   logic        fpu_flag_valid = 1'b0;
   logic [4:0]  fpu_flags = '0;
   logic        csrW_en;
   logic [11:0] csr_address_w, csr_address_r;
   logic [31:0] csr_data_w, csr_data_r;
   logic [31:0] mem [0:4095];
   logic        mem_init = 1'b0;
   int          total = 0, bad = 0;

   csr_access_ctrl dut (
      .clk(clk), .rst(rst),
      .trap_req(trap_req), .trap_epc(trap_epc), .trap_cause(trap_cause), .trap_tval(trap_tval),
      .trap_done(trap_done), .trap_vec(trap_vec),
      .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready), .csr_req_op(csr_req_op),
      .csr_req_addr(csr_req_addr), .csr_req_wdata(csr_req_wdata),
      .csr_rsp_valid(csr_rsp_valid), .csr_rsp_rdata(csr_rsp_rdata),
      .fpu_flag_valid(fpu_flag_valid), .fpu_flags(fpu_flags),
      .csrW_en(csrW_en), .csr_address_w(csr_address_w), .csr_data_w(csr_data_w),
      .csr_address_r(csr_address_r), .csr_data_r(csr_data_r)
   );

   always #5 clk = ~clk;
   assign csr_data_r = mem[csr_address_r];
   always @(negedge clk)
      if (!mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= '0;
         mem[12'h305] <= 32'h80;
         mem[12'h300] <= 32'h1;
         mem_init     <= 1'b1;
      end else if (csrW_en) mem[csr_address_w] <= csr_data_w;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      tick();
      total++;
      if ({csrW_en, csr_req_ready, csr_rsp_valid, trap_done, csr_address_w, csr_data_w,
           csr_address_r, csr_rsp_rdata, trap_vec} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got we=%b rdy=%b rsp=%b done=%b aw=%h dw=%h ar=%h rd=%h vec=%h want all 0",
                  csrW_en, csr_req_ready, csr_rsp_valid, trap_done, csr_address_w, csr_data_w,
                  csr_address_r, csr_rsp_rdata, trap_vec);
      end
      rst = 1'b1;
      tick();
      total++;
      if ({csrW_en, csr_req_ready} !== 2'b00) begin
         bad++;
         $display("FAIL idle_after_reset got we=%b rdy=%b want 0 0", csrW_en, csr_req_ready);
      end
   endtask

   task automatic test_trap;
      trap_req = 1'b1; trap_epc = 32'h1000; trap_cause = 32'h2; trap_tval = 32'hDEAD_BEEF;
      tick();
      total++;
      if ({csrW_en, csr_address_w, csr_data_w} !== {1'b1, 12'h341, 32'h1000}) begin
         bad++;
         $display("FAIL trap_mepc got %b/%h/%h want 1/341/00001000", csrW_en, csr_address_w, csr_data_w);
      end
      tick();
      total++;
      if ({csrW_en, csr_address_w, csr_data_w} !== {1'b1, 12'h342, 32'h2}) begin
         bad++;
         $display("FAIL trap_mcause got %b/%h/%h want 1/342/00000002", csrW_en, csr_address_w, csr_data_w);
      end
      tick();
      total++;
      if ({csrW_en, csr_address_w, csr_data_w} !== {1'b1, 12'h343, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL trap_mtval got %b/%h/%h want 1/343/deadbeef", csrW_en, csr_address_w, csr_data_w);
      end
      tick();
      total++;
      if ({trap_done, trap_vec, csrW_en} !== {1'b1, 32'h80, 1'b0}) begin
         bad++;
         $display("FAIL trap_done got done=%b vec=%h we=%b want 1/00000080/0", trap_done, trap_vec, csrW_en);
      end
      trap_req = 1'b0;
      tick();
      total++;
      if ({trap_done, mem[12'h341], mem[12'h342], mem[12'h343]} !== {1'b0, 32'h1000, 32'h2, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL trap_file got done=%b %h %h %h want 0 00001000 00000002 deadbeef",
                  trap_done, mem[12'h341], mem[12'h342], mem[12'h343]);
      end
   endtask

   task automatic test_csrrs;
      csr_req_valid = 1'b1; csr_req_op = 2'b10; csr_req_addr = 12'h300; csr_req_wdata = 32'h8;
      #1;
      total++;
      if (csr_req_ready !== 1'b1) begin
         bad++;
         $display("FAIL rs_ready got %b want 1", csr_req_ready);
      end
      tick();
      csr_req_valid = 1'b0;
      total++;
      if ({csrW_en, csr_rsp_valid, csr_address_r} !== {2'b00, 12'h300}) begin
         bad++;
         $display("FAIL rs_read got we=%b rsp=%b ar=%h want 0 0 300", csrW_en, csr_rsp_valid, csr_address_r);
      end
      tick();
      total++;
      if ({csr_rsp_valid, csr_rsp_rdata} !== {1'b1, 32'h1}) begin
         bad++;
         $display("FAIL rs_rsp got %b/%h want 1/00000001", csr_rsp_valid, csr_rsp_rdata);
      end
      total++;
      if ({csrW_en, csr_address_w, csr_data_w} !== {1'b1, 12'h300, 32'h9}) begin
         bad++;
         $display("FAIL rs_write got %b/%h/%h want 1/300/00000009", csrW_en, csr_address_w, csr_data_w);
      end
      tick();
      total++;
      if ({csr_rsp_valid, mem[12'h300]} !== {1'b0, 32'h9}) begin
         bad++;
         $display("FAIL rs_file got rsp=%b mstatus=%h want 0 00000009", csr_rsp_valid, mem[12'h300]);
      end
   endtask

   task automatic test_csrrc_zero;
      csr_req_valid = 1'b1; csr_req_op = 2'b11; csr_req_addr = 12'h300; csr_req_wdata = 32'h0;
      tick();
      csr_req_valid = 1'b0;
      total++;
      if (csrW_en !== 1'b0) begin
         bad++;
         $display("FAIL rc0_we_rd got %b want 0", csrW_en);
      end
      tick();
      total++;
      if ({csrW_en, csr_rsp_valid, csr_rsp_rdata} !== {2'b01, 32'h9}) begin
         bad++;
         $display("FAIL rc0_wr got we=%b rsp=%b rd=%h want 0 1 00000009", csrW_en, csr_rsp_valid, csr_rsp_rdata);
      end
      tick();
      total++;
      if (mem[12'h300] !== 32'h9) begin
         bad++;
         $display("FAIL rc0_file got %h want 00000009", mem[12'h300]);
      end
   endtask

   task automatic test_flags;
      fpu_flag_valid = 1'b1; fpu_flags = 5'h01;
      tick();
      fpu_flag_valid = 1'b0;
      tick();
      total++;
      if ({csrW_en, csr_address_r} !== {1'b0, 12'h001}) begin
         bad++;
         $display("FAIL flg_read got we=%b ar=%h want 0 001", csrW_en, csr_address_r);
      end
      tick();
      fpu_flag_valid = 1'b1; fpu_flags = 5'h04;
      total++;
      if ({csrW_en, csr_address_w, csr_data_w} !== {1'b1, 12'h001, 32'h1}) begin
         bad++;
         $display("FAIL flg_write1 got %b/%h/%h want 1/001/00000001", csrW_en, csr_address_w, csr_data_w);
      end
      tick();
      fpu_flag_valid = 1'b0;
      tick(2);
      total++;
      if ({csrW_en, csr_address_w, csr_data_w} !== {1'b1, 12'h001, 32'h5}) begin
         bad++;
         $display("FAIL flg_write2 got %b/%h/%h want 1/001/00000005", csrW_en, csr_address_w, csr_data_w);
      end
      tick();
      total++;
      if ({mem[12'h001], dut.pend_flags} !== {32'h5, 5'h0}) begin
         bad++;
         $display("FAIL flg_final got fflags=%h pend=%h want 00000005 00", mem[12'h001], dut.pend_flags);
      end
      tick(2);
      total++;
      if (csrW_en !== 1'b0) begin
         bad++;
         $display("FAIL flg_quiet got we=%b want 0", csrW_en);
      end
   endtask

   task automatic test_contention;
      trap_req = 1'b1; trap_epc = 32'h2000; trap_cause = 32'h5; trap_tval = 32'h11;
      csr_req_valid = 1'b1; csr_req_op = 2'b01; csr_req_addr = 12'h340; csr_req_wdata = 32'hABCD;
      fpu_flag_valid = 1'b1; fpu_flags = 5'h02;
      #1;
      total++;
      if (csr_req_ready !== 1'b0) begin
         bad++;
         $display("FAIL ct_ready_accept got %b want 0", csr_req_ready);
      end
      tick();
      fpu_flag_valid = 1'b0;
      total++;
      if ({csr_req_ready, csrW_en, csr_address_w, csr_data_w} !== {2'b01, 12'h341, 32'h2000}) begin
         bad++;
         $display("FAIL ct_trap_first got rdy=%b %b/%h/%h want 0 1/341/00002000",
                  csr_req_ready, csrW_en, csr_address_w, csr_data_w);
      end
      tick(3);
      total++;
      if ({trap_done, trap_vec, csr_req_ready} !== {1'b1, 32'h80, 1'b0}) begin
         bad++;
         $display("FAIL ct_trap_done got done=%b vec=%h rdy=%b want 1 00000080 0", trap_done, trap_vec, csr_req_ready);
      end
      trap_req = 1'b0;
      tick();
      total++;
      if ({csr_req_ready, csrW_en} !== 2'b10) begin
         bad++;
         $display("FAIL ct_ready_idle got rdy=%b we=%b want 1 0", csr_req_ready, csrW_en);
      end
      tick();
      csr_req_valid = 1'b0;
      tick();
      total++;
      if ({csrW_en, csr_address_w, csr_data_w, csr_rsp_valid, csr_rsp_rdata} !==
          {1'b1, 12'h340, 32'hABCD, 1'b1, 32'h0}) begin
         bad++;
         $display("FAIL ct_csr got %b/%h/%h rsp=%b rd=%h want 1/340/0000abcd 1 00000000",
                  csrW_en, csr_address_w, csr_data_w, csr_rsp_valid, csr_rsp_rdata);
      end
      tick(3);
      total++;
      if ({csrW_en, csr_address_w, csr_data_w} !== {1'b1, 12'h001, 32'h7}) begin
         bad++;
         $display("FAIL ct_flags got %b/%h/%h want 1/001/00000007", csrW_en, csr_address_w, csr_data_w);
      end
      tick();
      total++;
      if (mem[12'h001] !== 32'h7) begin
         bad++;
         $display("FAIL ct_fflags got %h want 00000007", mem[12'h001]);
      end
   endtask

   task automatic test_reset_mid;
      csr_req_valid = 1'b1; csr_req_op = 2'b01; csr_req_addr = 12'h300; csr_req_wdata = 32'h55;
      tick();
      csr_req_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      total++;
      if ({csrW_en, csr_rsp_valid, trap_done, csr_address_w, csr_data_w, csr_address_r, csr_rsp_rdata} !== '0) begin
         bad++;
         $display("FAIL rstmid_outputs got we=%b rsp=%b done=%b aw=%h dw=%h ar=%h rd=%h want all 0",
                  csrW_en, csr_rsp_valid, trap_done, csr_address_w, csr_data_w, csr_address_r, csr_rsp_rdata);
      end
      tick();
      rst = 1'b1;
      tick();
      total++;
      if ({csrW_en, csr_rsp_valid} !== 2'b00) begin
         bad++;
         $display("FAIL rstmid_quiet got we=%b rsp=%b want 0 0", csrW_en, csr_rsp_valid);
      end
      total++;
      if (mem[12'h300] !== 32'h9) begin
         bad++;
         $display("FAIL rstmid_file got %h want 00000009", mem[12'h300]);
      end
   endtask

   initial begin
      test_reset();
      test_trap();
      test_csrrs();
      test_csrrc_zero();
      test_flags();
      test_contention();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
